// File: rtl/vpu_issue_ctrl.sv
// Issue controller between the tensorcore decoder and the SIMD vector unit.
// Queues decoded VPU instructions and launches them one at a time.
module vpu_issue_ctrl #(
   parameter int unsigned INSTR_W = 78,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [INSTR_W-1:0]     in_instr,
   output logic                   in_ready,
   input  logic                   enable,
   input  logic                   flush,
   input  logic                   clr_err,
   output logic [INSTR_W-1:0]     vpu_instr,
   output logic                   vpu_start,
   input  logic                   vpu_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]       retired,
   output logic                   err_timeout
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned FC_W  = PTR_W + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
   logic [FC_W-1:0]    count_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [INSTR_W-1:0] instr_d;
   logic [CNT_W-1:0]   retired_d;
   logic               start_d, err_d, busy_d, ready_d;
   logic               in_flight, push, done_hit, tmo_hit, pop;

   // The head entry stays in the FIFO while in flight; it is popped on retire or timeout.
   assign in_flight = (state_q != S_IDLE);
   assign push      = in_valid && in_ready && !flush;
   assign done_hit  = (state_q == S_WAIT) && vpu_done;
   assign tmo_hit   = (state_q == S_WAIT) && !vpu_done && (tmr_q == TMR_W'(TIMEOUT - 1));
   assign pop       = done_hit || tmo_hit;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (enable && (fifo_count != '0) && !flush) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (pop) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath
   always_comb begin
      wr_ptr_d = wr_ptr;
      rd_ptr_d = rd_ptr + PTR_W'(pop);
      count_d  = fifo_count;
      if (flush) begin
         // Keep only the in-flight head, unless it is retiring this same cycle.
         wr_ptr_d = rd_ptr + PTR_W'(in_flight);
         count_d  = (in_flight && !pop) ? FC_W'(1) : '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr + PTR_W'(1);
         count_d = fifo_count + FC_W'(push) - FC_W'(pop);
      end
      ready_d   = (count_d < FC_W'(DEPTH));
      start_d   = (state_d == S_ISSUE);
      instr_d   = ((state_q == S_IDLE) && (state_d == S_ISSUE)) ? mem[rd_ptr] : vpu_instr;
      tmr_d     = tmr_q;
      if (state_d == S_ISSUE) tmr_d = '0;
      else if (in_flight)     tmr_d = tmr_q + TMR_W'(1);
      retired_d = retired + CNT_W'(done_hit);
      err_d     = tmo_hit ? 1'b1 : (clr_err ? 1'b0 : err_timeout);
      busy_d    = (state_d != S_IDLE) || (count_d != '0);
   end

   // Output and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         in_ready    <= 1'b0;
         vpu_start   <= 1'b0;
         vpu_instr   <= '0;
         tmr_q       <= '0;
         retired     <= '0;
         err_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_d;
         rd_ptr      <= rd_ptr_d;
         fifo_count  <= count_d;
         in_ready    <= ready_d;
         vpu_start   <= start_d;
         vpu_instr   <= instr_d;
         tmr_q       <= tmr_d;
         retired     <= retired_d;
         err_timeout <= err_d;
         busy        <= busy_d;
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_instr;
   end

endmodule

// File: doc/vpu_issue_ctrl.md
Name: vpu_issue_ctrl

Overview:
- Instruction issue controller that sits between the tensorcore decoder and the SIMD vector unit.
- Buffers decoded VPU instructions in a small FIFO and launches them one at a time with a single-cycle start pulse.
- Holds all instruction fields stable until the unit returns done, then retires the instruction.
- Provides flush, a done-timeout watchdog, and occupancy/retire counters for the host.

Parameters:
- INSTR_W, 78, packed instruction width. Layout MSB→LSB: addr_a[13], addr_b[13], addr_out[13], opcode[10], addr_const[13], vpu_type[3], vreg_dst[3], vreg_a[3], vreg_b[3], vpu_opcode[3], scalar_b[1].
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TIMEOUT, 1024, cycles allowed in WAIT before abort; ≥8.
- CNT_W, 16, width of the retire counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, decoder offers an instruction.
- in_instr, input, INSTR_W, packed instruction.
- in_ready, output, 1, FIFO can accept.
- enable, input, 1, issue permitted when high.
- flush, input, 1, discard queued (not in-flight) entries.
- clr_err, input, 1, clears err_timeout.
- vpu_instr, output, INSTR_W, fields to the vector unit.
- vpu_start, output, 1, one-cycle launch pulse.
- vpu_done, input, 1, completion pulse from the vector unit.
- busy, output, 1, state≠IDLE or FIFO non-empty.
- fifo_count, output, $clog2(DEPTH)+1, occupancy.
- retired, output, CNT_W, completed-instruction count; wraps.
- err_timeout, output, 1, sticky watchdog flag.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; FIFO empty.
  - vpu_start=0, vpu_instr=0, retired=0, err_timeout=0, fifo_count=0, busy=0.
  - in_ready=1 once reset is released.
  - Reset mid-WAIT abandons the in-flight instruction silently.
- Enqueue:
  - Push when in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH); it is registered-count based, with no same-cycle pop bypass.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- vpu_instr is registered and always equals the FIFO head entry latched at ISSUE. It is held constant from ISSUE through the cycle after vpu_done, because the unit routes BRAM/done combinationally on vpu_type.
- State machine:
  - IDLE → ISSUE when enable && FIFO non-empty && !flush. vpu_instr <= head.
  - ISSUE: vpu_start=1 for exactly this cycle; timeout counter cleared; → WAIT.
  - WAIT: counter increments each cycle.
    - On vpu_done: pop head, retired+1, → IDLE.
    - Else if counter == TIMEOUT-1: pop head, err_timeout=1, retired unchanged, → IDLE.
  - At most one instruction is in flight. Minimum issue spacing = unit latency + 2 cycles (IDLE bubble).
- vpu_done outside WAIT is ignored and does not change retired.
- Flush:
  - Takes effect in one cycle. Empties every FIFO entry except the in-flight head during ISSUE/WAIT.
  - The in-flight instruction still completes or times out normally.
  - A push in the flush cycle is dropped.
- enable deassert: no new issue; the in-flight instruction completes.
- clr_err clears err_timeout. If clr_err and a timeout occur in the same cycle, set wins.
- retired wraps from 2^CNT_W-1 to 0.
- fifo_count reports entries including the in-flight head; it decrements on the retire/timeout pop.

Test Plan:
- Push 3 instrs (vpu_type=1,2,3), enable=1, vpu_done 12 cycles after each start → exactly 3 single-cycle start pulses, in order; vpu_instr stable between each start and its done; retired=3; busy=0 at end.
- Push 5 instrs back-to-back with enable=0 → first 4 accepted, in_ready=0 on the 5th with fifo_count=4; after enable and one retire, in_ready=1 again.
- Issue one instr, never assert vpu_done → err_timeout=1 exactly TIMEOUT cycles after start; retired=0; next queued instr issues. clr_err → flag clears.
- Queue 4, flush during first WAIT → fifo_count=1; done retires it; retired=1; no further starts.
- Assert vpu_done while IDLE with empty FIFO → retired and state unchanged. Preload retired to 0xFFFF, retire one → 0x0000.
- Assert rst_n low mid-WAIT → all outputs zero immediately; after release, a fresh push issues normally.
